wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Parametrised Wishbone master arbiter between N internal bus masters (fetcher, load, store, future DMA/debug) and the single external Wishbone port of the dcpu.
- Replaces the fixed 3-way combinational priority mux in the CPU top with registered grant arbitration.
- Grant is held for the whole cycle (cyc-locked).
- Adds selectable fixed-priority or round-robin arbitration and a bus-timeout watchdog.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8); index 0 = fetcher
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; byte-select width SEL_WIDTH = DATA_WIDTH/8
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT_CYCLES, 255, stalled-transfer limit in cycles; 0 disables watchdog

Ports:
i_clk  in  1  clock; all state changes on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_m_cyc  in  NUM_MASTERS  per-master cyc (request)
i_m_stb  in  NUM_MASTERS*SEL_WIDTH  per-master byte strobes, master k at [k*SEL_WIDTH +: SEL_WIDTH]
i_m_we  in  NUM_MASTERS  per-master write enable
i_m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address, packed as for i_m_stb
i_m_dat  in  NUM_MASTERS*DATA_WIDTH  per-master write data, packed as for i_m_stb
o_m_dat  out  DATA_WIDTH  read data, broadcast to all masters
o_m_ack  out  NUM_MASTERS  ack, routed to granted master only
o_m_err  out  NUM_MASTERS  err, routed to granted master only; also carries timeout error
o_grant  out  NUM_MASTERS  one-hot registered grant, all-zero when idle
o_timeout  out  1  one-cycle pulse when watchdog fires
o_wb_addr  out  ADDR_WIDTH  external address
o_wb_cyc  out  1  external cyc
o_wb_stb  out  SEL_WIDTH  external byte strobes
o_wb_we  out  1  external write enable
o_wb_dat  out  DATA_WIDTH  external write data
i_wb_dat  in  DATA_WIDTH  external read data
i_wb_ack  in  1  external ack
i_wb_err  in  1  external err

Behaviour:
- Reset (async, i_reset_n=0):
  - State forced to IDLE; o_grant=0; round-robin pointer = NUM_MASTERS-1 (so master 0 wins first); watchdog counter = 0.
  - All outputs 0 immediately, including mid-transfer.
- IDLE:
  - o_wb_* all 0; o_m_ack/o_m_err 0.
  - If any i_m_cyc=1, winner registered into o_grant at the next edge; state -> GRANTED.
  - Latency: request seen at edge n, o_wb_cyc high after edge n+1.
- Arbitration:
  - Fixed: lowest set index of i_m_cyc.
  - Round-robin: first set index searching upward from pointer+1, wrapping modulo NUM_MASTERS; pointer updated to the winner on grant.
- GRANTED:
  - o_wb_cyc/stb/we/addr/dat combinationally muxed from granted master g; o_wb_cyc = i_m_cyc[g].
  - o_m_ack[g] = i_wb_ack; o_m_err[g] = i_wb_err.
  - If i_wb_ack and i_wb_err are both high, err is forwarded and ack suppressed.
  - Other masters see ack/err = 0; their requests wait.
  - When i_m_cyc[g] falls, o_wb_cyc falls the same cycle; next edge -> IDLE, o_grant=0.
  - Guaranteed one idle bus cycle between grants (turnaround).
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each GRANTED cycle with o_wb_cyc=1, o_wb_stb!=0, i_wb_ack=0, i_wb_err=0.
  - Counter clears on ack, err, or leaving GRANTED.
  - When counter == TIMEOUT_CYCLES-1 and still no ack/err, at next edge -> ABORT.
  - Ack/err arriving in that final cycle wins: no abort, counter cleared.
  - Counter saturates; 8..16 bits sized by $clog2(TIMEOUT_CYCLES+1).
- ABORT:
  - o_wb_cyc/stb forced 0.
  - First ABORT cycle only: o_m_err[g]=1 and o_timeout=1.
  - External ack/err ignored.
  - Remains in ABORT until i_m_cyc[g]=0, then IDLE.
- Default/illegal state -> IDLE.
- o_m_dat = i_wb_dat always (unregistered).

Decomposition:
- defines.v gains the arbiter state encodings (ARB_IDLE=0, ARB_GRANTED=1, ARB_ABORT=2) and mode constants (ARB_MODE_FIXED=0, ARB_MODE_RR=1).
- One sub-module: arb_pick, a combinational rotating priority picker. Inputs: request vector, base index. Outputs: one-hot winner and index. Fixed mode uses base = NUM_MASTERS-1.

Test Plan:
1. Reset mid-transfer: master 1 granted, o_wb_cyc=1; pulse i_reset_n low between edges -> o_wb_cyc, o_grant, o_wb_addr all 0 immediately.
2. Fixed priority, N=3: i_m_cyc=3'b110 at edge 0 -> o_grant=3'b010 after edge 1, o_wb_addr = master-1 address. Master 1 drops cyc after ack -> idle cycle, then o_grant=3'b100.
3. Round-robin, N=3: all three request continuously, each drops cyc one cycle after ack -> grant sequence 001, 010, 100, 001 with one idle cycle between each.
4. Routing: master 2 granted, slave ack with i_wb_dat=32'hDEADBEEF -> o_m_ack=3'b100, o_m_dat=32'hDEADBEEF. Same cycle ack+err -> o_m_err=3'b100, o_m_ack=0.
5. Timeout, TIMEOUT_CYCLES=4: master 0 stb held, no ack -> after 4 stalled cycles o_timeout and o_m_err[0] pulse one cycle, o_wb_cyc=0. Ack arriving in the 4th stalled cycle -> no timeout.
6. Write path: master 1 we=1, stb=4'b0011, addr=32'h100, dat=32'h1234 -> o_wb_we=1, o_wb_stb=4'b0011, o_wb_addr=32'h100, o_wb_dat=32'h1234 while granted.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
//   Shared definitions for the Wishbone master arbiter: FSM state encoding,
//   arbitration mode constants and the watchdog counter sizing helper.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_ABORT   = 2'd2
  } arb_state_t;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  // Watchdog counter width: enough for TIMEOUT_CYCLES, clamped to 8..16 bits.
  function automatic int wd_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    if (w < 8)  return 8;
    if (w > 16) return 16;
    return w;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
//   Bundles the per-master request side and the external Wishbone port.
//   Per-master vectors are packed with master k at [k*W +: W].
//   modport master : the arbiter itself (it is the master on the external bus)
//   modport slave  : the environment (requesting masters + external slave)
interface wb_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // Internal masters -> arbiter
  logic [NUM_MASTERS-1:0]            i_m_cyc;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  i_m_stb;
  logic [NUM_MASTERS-1:0]            i_m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_dat;
  // Arbiter -> internal masters
  logic [DATA_WIDTH-1:0]             o_m_dat;
  logic [NUM_MASTERS-1:0]            o_m_ack;
  logic [NUM_MASTERS-1:0]            o_m_err;
  logic [NUM_MASTERS-1:0]            o_grant;
  logic                              o_timeout;
  // External Wishbone port
  logic [ADDR_WIDTH-1:0]             o_wb_addr;
  logic                              o_wb_cyc;
  logic [SEL_WIDTH-1:0]              o_wb_stb;
  logic                              o_wb_we;
  logic [DATA_WIDTH-1:0]             o_wb_dat;
  logic [DATA_WIDTH-1:0]             i_wb_dat;
  logic                              i_wb_ack;
  logic                              i_wb_err;

  modport master (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_dat,
    input  i_wb_dat, i_wb_ack, i_wb_err,
    output o_m_dat, o_m_ack, o_m_err, o_grant, o_timeout,
    output o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat
  );

  modport slave (
    output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_dat,
    output i_wb_dat, i_wb_ack, i_wb_err,
    input  o_m_dat, o_m_ack, o_m_err, o_grant, o_timeout,
    input  o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat
  );

endinterface

// File: rtl/wb_arbiter_arb_pick.sv
// arb_pick
//   Combinational rotating priority picker. Searches req upward starting at
//   base+1, wrapping modulo NUM_MASTERS; base = NUM_MASTERS-1 gives plain
//   lowest-index-wins priority.
//   req    : request vector
//   base   : index just below the highest-priority position
//   winner : one-hot winner (all zero when no request)
//   index  : binary winner index
//   valid  : at least one request present
module arb_pick #(
  parameter int NUM_MASTERS = 3,
  localparam int IW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          base,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IW-1:0]          index,
  output logic                   valid
);

  logic [IW-1:0] k;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (which would infer a latch).
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    k      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      k = IW'((int'(base) + i) % NUM_MASTERS);
      if (!valid && req[k]) begin
        valid     = 1'b1;
        winner[k] = 1'b1;
        index     = k;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Registered, cyc-locked arbiter between NUM_MASTERS internal Wishbone
//   masters and one external Wishbone port, with fixed-priority or
//   round-robin selection and a stalled-transfer watchdog.
//   i_clk     : clock, all state changes on the rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : master-side and external bus signals (see wb_arbiter_if)
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = ARB_MODE_FIXED,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  wb_arbiter_if.master bus
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int IW    = $clog2(NUM_MASTERS);
  localparam int CW    = wd_width(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] WD_LAST = CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] grant;
  logic [IW-1:0]          gidx;
  logic [IW-1:0]          rr_ptr;
  logic [CW-1:0]          wd_cnt;
  logic                   abort_first;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [IW-1:0]          pick_base;

  // Fixed priority is the rotating picker anchored just below index 0.
  assign pick_base = (ROUND_ROBIN == ARB_MODE_RR) ? rr_ptr : IW'(NUM_MASTERS - 1);

  arb_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req    (bus.i_m_cyc),
    .base   (pick_base),
    .winner (pick_oh),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  logic          g_cyc;
  logic [SW-1:0] g_stb;
  logic          stalled;
  logic          wd_fire;

  assign g_cyc   = bus.i_m_cyc[gidx];
  assign g_stb   = bus.i_m_stb[int'(gidx)*SW +: SW];
  assign stalled = (state == ARB_GRANTED) && g_cyc && (|g_stb)
                   && !bus.i_wb_ack && !bus.i_wb_err;
  // Fires on the last tolerated stalled cycle; an ack/err in that cycle
  // clears 'stalled' and so wins over the abort.
  assign wd_fire = WD_EN && stalled && (wd_cnt == WD_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      gidx        <= '0;
      rr_ptr      <= IW'(NUM_MASTERS - 1);
      wd_cnt      <= '0;
      abort_first <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      case (state)
        ARB_IDLE: begin
          wd_cnt      <= '0;
          abort_first <= 1'b0;
          if (pick_valid) begin
            state  <= ARB_GRANTED;
            grant  <= pick_oh;
            gidx   <= pick_idx;
            rr_ptr <= pick_idx;
          end
        end
        ARB_GRANTED: begin
          if (!g_cyc) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            wd_cnt <= '0;
          end else if (wd_fire) begin
            state       <= ARB_ABORT;
            abort_first <= 1'b1;
            wd_cnt      <= '0;
          end else if (stalled) begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          end else if (bus.i_wb_ack || bus.i_wb_err) begin
            wd_cnt <= '0;
          end
        end
        ARB_ABORT: begin
          abort_first <= 1'b0;
          if (!g_cyc) begin
            state <= ARB_IDLE;
            grant <= '0;
          end
        end
        default: begin
          state       <= ARB_IDLE;
          grant       <= '0;
          wd_cnt      <= '0;
          abort_first <= 1'b0;
        end
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0]  wb_addr;
  logic                   wb_cyc;
  logic [SW-1:0]          wb_stb;
  logic                   wb_we;
  logic [DATA_WIDTH-1:0]  wb_dat;
  logic [NUM_MASTERS-1:0] m_ack;
  logic [NUM_MASTERS-1:0] m_err;

  always_comb begin
    wb_addr = '0;
    wb_cyc  = 1'b0;
    wb_stb  = '0;
    wb_we   = 1'b0;
    wb_dat  = '0;
    m_ack   = '0;
    m_err   = '0;
    if (state == ARB_GRANTED) begin
      wb_cyc      = g_cyc;
      wb_stb      = g_stb;
      wb_we       = bus.i_m_we[gidx];
      wb_addr     = bus.i_m_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      wb_dat      = bus.i_m_dat[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      // Simultaneous ack+err is reported as an error only.
      m_err[gidx] = bus.i_wb_err;
      m_ack[gidx] = bus.i_wb_ack && !bus.i_wb_err;
    end else if (state == ARB_ABORT) begin
      m_err[gidx] = abort_first;
    end
  end

  assign bus.o_wb_addr = wb_addr;
  assign bus.o_wb_cyc  = wb_cyc;
  assign bus.o_wb_stb  = wb_stb;
  assign bus.o_wb_we   = wb_we;
  assign bus.o_wb_dat  = wb_dat;
  assign bus.o_m_ack   = m_ack;
  assign bus.o_m_err   = m_err;
  assign bus.o_grant   = grant;
  assign bus.o_timeout = abort_first;
  // Read data is a plain broadcast; masters only use it alongside their ack.
  assign bus.o_m_dat   = bus.i_wb_dat;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]    m_cyc;
  logic [N*SW-1:0] m_stb;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   wb_dat;
  logic            wb_ack;
  logic            wb_err;

  wb_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fix ();
  wb_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();

  assign bus_fix.i_m_cyc  = m_cyc;   assign bus_rr.i_m_cyc  = m_cyc;
  assign bus_fix.i_m_stb  = m_stb;   assign bus_rr.i_m_stb  = m_stb;
  assign bus_fix.i_m_we   = m_we;    assign bus_rr.i_m_we   = m_we;
  assign bus_fix.i_m_addr = m_addr;  assign bus_rr.i_m_addr = m_addr;
  assign bus_fix.i_m_dat  = m_dat;   assign bus_rr.i_m_dat  = m_dat;
  assign bus_fix.i_wb_dat = wb_dat;  assign bus_rr.i_wb_dat = wb_dat;
  assign bus_fix.i_wb_ack = wb_ack;  assign bus_rr.i_wb_ack = wb_ack;
  assign bus_fix.i_wb_err = wb_err;  assign bus_rr.i_wb_err = wb_err;

  wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
               .ROUND_ROBIN(0), .TIMEOUT_CYCLES(T))
    dut_fix (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_fix));

  wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
               .ROUND_ROBIN(1), .TIMEOUT_CYCLES(T))
    dut_rr (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_rr));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0]  grant;
    logic          cyc;
    logic [SW-1:0] stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic [DW-1:0] mdat;
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic          tmo;
  } outs_t;

  function automatic outs_t get_outs(input int d);
    outs_t o;
    if (d == 0) begin
      o.grant = bus_fix.o_grant;  o.cyc = bus_fix.o_wb_cyc;  o.stb = bus_fix.o_wb_stb;
      o.we = bus_fix.o_wb_we;     o.addr = bus_fix.o_wb_addr; o.dat = bus_fix.o_wb_dat;
      o.mdat = bus_fix.o_m_dat;   o.ack = bus_fix.o_m_ack;   o.err = bus_fix.o_m_err;
      o.tmo = bus_fix.o_timeout;
    end else begin
      o.grant = bus_rr.o_grant;   o.cyc = bus_rr.o_wb_cyc;   o.stb = bus_rr.o_wb_stb;
      o.we = bus_rr.o_wb_we;      o.addr = bus_rr.o_wb_addr; o.dat = bus_rr.o_wb_dat;
      o.mdat = bus_rr.o_m_dat;    o.ack = bus_rr.o_m_ack;    o.err = bus_rr.o_m_err;
      o.tmo = bus_rr.o_timeout;
    end
    return o;
  endfunction

  task automatic compare_outs(input string tag, input outs_t a, input outs_t e);
    check({tag, ".grant"},   64'(a.grant), 64'(e.grant));
    check({tag, ".wb_cyc"},  64'(a.cyc),   64'(e.cyc));
    check({tag, ".wb_stb"},  64'(a.stb),   64'(e.stb));
    check({tag, ".wb_we"},   64'(a.we),    64'(e.we));
    check({tag, ".wb_addr"}, 64'(a.addr),  64'(e.addr));
    check({tag, ".wb_dat"},  64'(a.dat),   64'(e.dat));
    check({tag, ".m_dat"},   64'(a.mdat),  64'(e.mdat));
    check({tag, ".m_ack"},   64'(a.ack),   64'(e.ack));
    check({tag, ".m_err"},   64'(a.err),   64'(e.err));
    check({tag, ".timeout"}, 64'(a.tmo),   64'(e.tmo));
  endtask

  // ---------------- behavioural reference model ----------------
  // Bus ownership tracked as an integer owner (-1 = nobody), plus whether the
  // owner's transfer has been aborted and how many stalled cycles have passed.
  int owner[2];
  int stall_cnt[2];
  int last_win[2];
  bit aborted[2];
  bit abort_new[2];

  function automatic int pick(input logic [N-1:0] req, input int after);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (after + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; stall_cnt[d] = 0; last_win[d] = N - 1;
      aborted[d] = 1'b0; abort_new[d] = 1'b0;
    end
  endtask

  function automatic outs_t model_outs(input int d);
    outs_t e;
    int o;
    e = '{default: '0};
    o = owner[d];
    e.mdat = wb_dat;
    if (o >= 0) begin
      e.grant[o] = 1'b1;
      if (!aborted[d]) begin
        e.cyc  = m_cyc[o];
        e.stb  = m_stb[o*SW +: SW];
        e.we   = m_we[o];
        e.addr = m_addr[o*AW +: AW];
        e.dat  = m_dat[o*DW +: DW];
        if (wb_err) e.err[o] = 1'b1;
        else if (wb_ack) e.ack[o] = 1'b1;
      end else begin
        e.err[o] = abort_new[d];
        e.tmo    = abort_new[d];
      end
    end
    return e;
  endfunction

  task automatic model_step(input int d);
    int o;
    int w;
    bit is_stall;
    o = owner[d];
    if (o < 0) begin
      w = pick(m_cyc, (d == 1) ? last_win[d] : N - 1);
      if (w >= 0) begin
        owner[d] = w;
        last_win[d] = w;
      end
      stall_cnt[d] = 0;
    end else if (aborted[d]) begin
      abort_new[d] = 1'b0;
      if (!m_cyc[o]) begin
        owner[d] = -1;
        aborted[d] = 1'b0;
      end
    end else if (!m_cyc[o]) begin
      owner[d] = -1;
      stall_cnt[d] = 0;
    end else begin
      is_stall = (m_stb[o*SW +: SW] != 0) && !wb_ack && !wb_err;
      if (is_stall) begin
        stall_cnt[d]++;
        if (stall_cnt[d] >= T) begin
          aborted[d] = 1'b1;
          abort_new[d] = 1'b1;
          stall_cnt[d] = 0;
        end
      end else if (wb_ack || wb_err) begin
        stall_cnt[d] = 0;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0]  cyc;
    logic          ack;
    logic          err;
    logic [DW-1:0] wdat;
    logic [N-1:0]  grant;
    logic          wcyc;
    logic [AW-1:0] addr;
    logic [SW-1:0] stb;
    logic          we;
    logic [DW-1:0] dat;
    logic [N-1:0]  mack;
    logic [N-1:0]  merr;
  } vec_t;

  vec_t vecs[10];

  task automatic do_reset();
    rst_n  = 1'b0;
    m_cyc  = '0;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_fixed_masters();
    m_addr = {32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    m_dat  = {32'h0000_00C2, 32'h0000_1234, 32'h0000_00A0};
    m_stb  = {4'b1100, 4'b0011, 4'b1111};
    m_we   = 3'b010;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    outs_t a;
    outs_t e;
    logic [N-1:0] rr_exp[4];
    vec_t v;

    rst_n  = 1'b0;
    m_cyc  = '0;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat = '0;
    set_fixed_masters();

    // Reset state
    #1;
    for (int d = 0; d < 2; d++) begin
      a = get_outs(d);
      check($sformatf("reset%0d.grant", d),   64'(a.grant), 64'(0));
      check($sformatf("reset%0d.wb_cyc", d),  64'(a.cyc),   64'(0));
      check($sformatf("reset%0d.timeout", d), 64'(a.tmo),   64'(0));
      check($sformatf("reset%0d.m_err", d),   64'(a.err),   64'(0));
    end

    // Fixed priority, write path and routing (fixed-priority DUT)
    vecs[0] = '{3'b110, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 32'h000, 4'b0000, 1'b0, 32'h0,    3'b000, 3'b000};
    vecs[1] = '{3'b110, 1'b0, 1'b0, 32'h0,        3'b010, 1'b1, 32'h100, 4'b0011, 1'b1, 32'h1234, 3'b000, 3'b000};
    vecs[2] = '{3'b110, 1'b1, 1'b0, 32'hDEADBEEF, 3'b010, 1'b1, 32'h100, 4'b0011, 1'b1, 32'h1234, 3'b010, 3'b000};
    vecs[3] = '{3'b100, 1'b0, 1'b0, 32'h0,        3'b010, 1'b0, 32'h100, 4'b0011, 1'b1, 32'h1234, 3'b000, 3'b000};
    vecs[4] = '{3'b100, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 32'h000, 4'b0000, 1'b0, 32'h0,    3'b000, 3'b000};
    vecs[5] = '{3'b100, 1'b0, 1'b0, 32'h0,        3'b100, 1'b1, 32'h200, 4'b1100, 1'b0, 32'hC2,   3'b000, 3'b000};
    vecs[6] = '{3'b100, 1'b1, 1'b0, 32'hDEADBEEF, 3'b100, 1'b1, 32'h200, 4'b1100, 1'b0, 32'hC2,   3'b100, 3'b000};
    vecs[7] = '{3'b100, 1'b1, 1'b1, 32'hDEADBEEF, 3'b100, 1'b1, 32'h200, 4'b1100, 1'b0, 32'hC2,   3'b000, 3'b100};
    vecs[8] = '{3'b000, 1'b0, 1'b0, 32'h0,        3'b100, 1'b0, 32'h200, 4'b1100, 1'b0, 32'hC2,   3'b000, 3'b000};
    vecs[9] = '{3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 32'h000, 4'b0000, 1'b0, 32'h0,    3'b000, 3'b000};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      @(negedge clk);
      m_cyc = v.cyc; wb_ack = v.ack; wb_err = v.err; wb_dat = v.wdat;
      #1;
      e = '{default: '0};
      e.grant = v.grant; e.cyc = v.wcyc; e.stb = v.stb; e.we = v.we;
      e.addr = v.addr; e.dat = v.dat; e.mdat = v.wdat; e.ack = v.mack; e.err = v.merr;
      compare_outs($sformatf("vec%0d", i), get_outs(0), e);
    end

    // Reset pulse between edges while master 1 is mid-transfer
    do_reset();
    @(negedge clk); m_cyc = 3'b010;
    @(negedge clk); #1;
    a = get_outs(0);
    check("rstmid.pre_cyc",   64'(a.cyc),   64'(1));
    check("rstmid.pre_grant", 64'(a.grant), 64'(3'b010));
    rst_n = 1'b0;
    #1;
    a = get_outs(0);
    check("rstmid.wb_cyc",  64'(a.cyc),   64'(0));
    check("rstmid.grant",   64'(a.grant), 64'(0));
    check("rstmid.wb_addr", 64'(a.addr),  64'(0));
    rst_n = 1'b1;
    m_cyc = '0;

    // Round-robin rotation with all masters requesting
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    do_reset();
    @(negedge clk); m_cyc = 3'b111; #1;
    check("rr.first_idle", 64'(bus_rr.o_grant), 64'(0));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); wb_ack = 1'b1; #1;
      check($sformatf("rr%0d.grant", j), 64'(bus_rr.o_grant), 64'(rr_exp[j]));
      check($sformatf("rr%0d.m_ack", j), 64'(bus_rr.o_m_ack), 64'(rr_exp[j]));
      @(negedge clk); wb_ack = 1'b0; m_cyc = 3'b111 & ~rr_exp[j]; #1;
      check($sformatf("rr%0d.hold", j),   64'(bus_rr.o_grant),  64'(rr_exp[j]));
      check($sformatf("rr%0d.cyc_low", j), 64'(bus_rr.o_wb_cyc), 64'(0));
      @(negedge clk); m_cyc = 3'b111; #1;
      check($sformatf("rr%0d.turnaround", j), 64'(bus_rr.o_grant), 64'(0));
    end

    // Watchdog: four stalled cycles abort the transfer
    do_reset();
    @(negedge clk); m_cyc = 3'b001; #1;
    check("wd.idle", 64'(bus_fix.o_grant), 64'(0));
    for (int s = 1; s <= T; s++) begin
      @(negedge clk); #1;
      check($sformatf("wd.stall%0d.timeout", s), 64'(bus_fix.o_timeout), 64'(0));
      check($sformatf("wd.stall%0d.cyc", s),     64'(bus_fix.o_wb_cyc),  64'(1));
    end
    @(negedge clk); #1;
    check("wd.pulse.timeout", 64'(bus_fix.o_timeout), 64'(1));
    check("wd.pulse.m_err",   64'(bus_fix.o_m_err),   64'(3'b001));
    check("wd.pulse.cyc",     64'(bus_fix.o_wb_cyc),  64'(0));
    check("wd.pulse.stb",     64'(bus_fix.o_wb_stb),  64'(0));
    @(negedge clk); m_cyc = 3'b000; #1;
    check("wd.after.timeout", 64'(bus_fix.o_timeout), 64'(0));
    check("wd.after.m_err",   64'(bus_fix.o_m_err),   64'(0));
    check("wd.after.grant",   64'(bus_fix.o_grant),   64'(3'b001));
    @(negedge clk); #1;
    check("wd.release", 64'(bus_fix.o_grant), 64'(0));

    // Watchdog: ack in the final stalled cycle wins
    do_reset();
    @(negedge clk); m_cyc = 3'b001;
    for (int s = 1; s <= T - 1; s++) @(negedge clk);
    @(negedge clk); wb_ack = 1'b1; #1;
    check("wdack.m_ack", 64'(bus_fix.o_m_ack), 64'(3'b001));
    for (int s = 1; s <= T; s++) begin
      @(negedge clk); wb_ack = 1'b0; #1;
      check($sformatf("wdack.post%0d.timeout", s), 64'(bus_fix.o_timeout), 64'(0));
      check($sformatf("wdack.post%0d.cyc", s),     64'(bus_fix.o_wb_cyc),  64'(1));
    end
    m_cyc = '0;

    // Randomised traffic against the reference model, both modes
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 4) == 0) m_cyc[k] = ~m_cyc[k];
      for (int k = 0; k < N; k++) begin
        m_stb[k*SW +: SW]  = ($urandom_range(0, 7) == 0) ? 4'b0000 : SW'($urandom);
        m_addr[k*AW +: AW] = $urandom;
        m_dat[k*DW +: DW]  = $urandom;
      end
      m_we   = N'($urandom);
      wb_ack = ($urandom_range(0, 3) == 0);
      wb_err = ($urandom_range(0, 11) == 0);
      wb_dat = $urandom;
      #1;
      compare_outs("rand_fix", get_outs(0), model_outs(0));
      compare_outs("rand_rr",  get_outs(1), model_outs(1));
      @(posedge clk);
      model_step(0);
      model_step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
